load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle load/store unit between the CPU datapath and the 64-bit data memory. It accepts one byte/half/word/doubleword access per request and checks alignment. It extracts and sign- or zero-extends load data, and performs read-modify-write for sub-doubleword stores. The control unit issues a request, waits for `done`, and then takes `rdata` (loads) or proceeds (stores); a `misalign` pulse feeds the EPC/exception path.

## Interface
- `READ_LAT`, default 1: memory read latency in cycles from address presented to `mem_rdata` valid; legal range 1..4.

- `Clk`  in  1  clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request; sampled only while `busy`=0.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  0 byte, 1 half, 2 word, 3 doubleword.
- `uns`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `addr`  in  64  byte address.
- `wdata`  in  64  store data, right-aligned (low bytes used).
- `busy`  out  1  high from accept until the end of the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  high together with `done` when the access was misaligned.
- `rdata`  out  64  extended load result; held until the next accepted load.
- `mem_addr`  out  64  doubleword address: `addr[63:3]`,3'b000.
- `mem_wr`  out  1  memory write strobe.
- `mem_wdata`  out  64  memory write data.
- `mem_rdata`  in  64  memory read data.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- On accept, latch `we`, `size`, `uns`, `addr` and `wdata`; later input changes have no effect.
- Alignment check: half requires `addr[0]`=0; word requires `addr[1:0]`=0; double requires `addr[2:0]`=0; byte is always aligned.
- Transitions out of IDLE on accept:
  - misaligned → DONE with `misalign`=1; no memory access, `mem_wr` stays 0, `rdata` unchanged.
  - load → READ.
  - store double → WRITE.
  - store byte/half/word → READ.
- READ: `mem_addr` driven from the latched address. A wait counter runs `READ_LAT` cycles. On the last READ edge, capture `mem_rdata`.
  - Load: extract the lane at byte offset `off` = `addr[2:0]` (little-endian: byte `off` = bits `8*off+7 : 8*off`), extend to 64 bits per `uns`, write to `rdata`, go to DONE.
  - Store: replace bytes `off`..`off`+N-1 of the captured doubleword with the low N bytes of `wdata` (N = 1/2/4), keep the other bytes, latch the result as the write buffer, go to WRITE.
- WRITE: `mem_wr`=1 for exactly one cycle. `mem_wdata` = merged buffer, or `wdata` for a doubleword store. Go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Doubleword loads ignore `uns`.
- `req` is ignored while `busy`=1, including during DONE.

## Timing
- Accept edge = edge n.
- Load: `done` high in the cycle following edge n+`READ_LAT`. Default latency is 2 cycles from accept to `done`.
- Store double: WRITE in the cycle after edge n; `done` in the cycle after edge n+1.
- Sub-doubleword store: WRITE in the cycle after edge n+`READ_LAT`; `done` in the cycle after edge n+`READ_LAT`+1.
- Misaligned access: `done`+`misalign` in the cycle after edge n.
- `mem_addr` is stable from the cycle after accept through WRITE. It holds its last value in IDLE and DONE.
- Next accept is possible at the edge ending DONE+1; the minimum spacing between accepts is latency+1.
- Reset values: state IDLE; `busy`, `done`, `misalign`, `mem_wr` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0; wait counter = 0.
- Reset asserted mid-operation aborts immediately:
  - `mem_wr` drops asynchronously.
  - No `done` is produced.
  - The write may or may not have reached memory.
  - The next request after release behaves normally.

## Test plan
- Memory doubleword at 0x40 = 0x8877_6655_4433_2211, `READ_LAT`=1. Load byte signed at 0x47 → `rdata`=0xFFFF_FFFF_FFFF_FF88, `done` 2 cycles after accept, `mem_addr`=0x40, `mem_wr` never high.
- Same memory. Load half unsigned at 0x42 → `rdata`=0x0000_0000_0000_4433. Load word signed at 0x44 → 0xFFFF_FFFF_8877_6655.
- Store half, `wdata`=0x...ABCD, at 0x44 → exactly one `mem_wr` cycle with `mem_wdata`=0x8877_ABCD_4433_2211. Readback with load double at 0x40 matches.
- Store double 0x0123_4567_89AB_CDEF at 0x48 → `mem_wr` in the cycle after accept, `done` one cycle later, no READ state visited.
- Load word at 0x46 → `done`=`misalign`=1 one cycle after accept; `rdata` unchanged; no memory access. A `req` pulse during DONE is ignored.
- `READ_LAT`=3: assert `Reset` during READ of a load → `busy`=0 immediately, no `done`. After release, load byte unsigned at 0x40 → `rdata`=0x11, `done` 4 cycles after accept.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: aligned B/H/W/D accesses to 64-bit memory; loads take READ_LAT+1 cycles, sub-dword stores READ_LAT+2 (read-modify-write), dword stores 2, misaligned 1.
// No backpressure: one request in flight; req is ignored while busy, and the issuer waits for done.
module load_store_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

  localparam logic [2:0] LastWait = 3'(READ_LAT - 1);

  stateT       state, stateNext;
  logic        weQ, unsQ, misQ;
  logic [1:0]  sizeQ;
  logic [2:0]  offQ;
  logic [63:0] wdataQ;
  logic [2:0]  waitCnt;

  logic        accept, misalignIn, readLast;
  logic [63:0] laneData, loadExt, bitMask, merged;
  logic [7:0]  byteMask, laneMask;

  assign accept   = (state == IDLE) && req;
  assign readLast = (state == READ) && (waitCnt == LastWait);

  always_comb begin
    misalignIn = 1'b0;
    case (size)
      2'd1:    misalignIn = addr[0];
      2'd2:    misalignIn = |addr[1:0];
      2'd3:    misalignIn = |addr[2:0];
      default: misalignIn = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (misalignIn)              stateNext = DONE;
          else if (we && size == 2'd3) stateNext = WRITE;
          else                         stateNext = READ;
        end
      end
      READ:    if (readLast) stateNext = weQ ? WRITE : DONE;
      WRITE:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    mem_wr   = (state == WRITE);
    misalign = (state == DONE) && misQ;
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  assign laneData = mem_rdata >> {offQ, 3'b000};

  always_comb begin
    loadExt = laneData;
    case (sizeQ)
      2'd0:    loadExt = {{56{~unsQ & laneData[7]}},  laneData[7:0]};
      2'd1:    loadExt = {{48{~unsQ & laneData[15]}}, laneData[15:0]};
      2'd2:    loadExt = {{32{~unsQ & laneData[31]}}, laneData[31:0]};
      default: loadExt = laneData;
    endcase
  end

  // Store path: overlay the low N bytes of wdata onto the fetched doubleword.
  always_comb begin
    case (sizeQ)
      2'd0:    byteMask = 8'h01;
      2'd1:    byteMask = 8'h03;
      2'd2:    byteMask = 8'h0F;
      default: byteMask = 8'hFF;
    endcase
    laneMask = byteMask << offQ;
    for (int b = 0; b < 8; b++) bitMask[8*b +: 8] = {8{laneMask[b]}};
    merged = (mem_rdata & ~bitMask) | ((wdataQ << {offQ, 3'b000}) & bitMask);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      weQ       <= 1'b0;
      unsQ      <= 1'b0;
      misQ      <= 1'b0;
      sizeQ     <= 2'd0;
      offQ      <= 3'd0;
      wdataQ    <= 64'd0;
      waitCnt   <= 3'd0;
      rdata     <= 64'd0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
    end else begin
      if (accept) begin
        weQ     <= we;
        unsQ    <= uns;
        misQ    <= misalignIn;
        sizeQ   <= size;
        offQ    <= addr[2:0];
        wdataQ  <= wdata;
        waitCnt <= 3'd0;
        // A misaligned access never touches memory, so the bus keeps its last address.
        if (!misalignIn) mem_addr <= {addr[63:3], 3'b000};
        if (!misalignIn && we && size == 2'd3) mem_wdata <= wdata;
      end
      if (state == READ) begin
        waitCnt <= readLast ? 3'd0 : waitCnt + 3'd1;
        if (readLast) begin
          if (weQ) mem_wdata <= merged;
          else     rdata     <= loadExt;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench: two LSU instances (READ_LAT 1 and 3) with memory models; a byte-array reference
// model predicts results, a negedge monitor pops and compares every done and mem_wr.
module tb_load_store_unit;

  typedef struct {
    logic [63:0] maddr;
    logic [63:0] rd;
    logic        mis;
    int          acc;
    int          doneOff;
  } expT;

  typedef struct {
    logic [63:0] maddr;
    logic [63:0] data;
    int          acc;
    int          off;
  } wrT;

  logic        Clk = 1'b0;
  logic        rstN [2];
  logic        req [2], we [2], uns [2];
  logic [1:0]  size [2];
  logic [63:0] addr [2], wdata [2];
  logic        busy [2], done [2], misalign [2], memWr [2];
  logic [63:0] rdata [2], memAddr [2], memWdata [2], memRdata [2];

  logic [7:0]  refB [2][512];
  logic [63:0] lastRd [2];
  expT         expQ [2][$];
  wrT          wrQ [2][$];

  int   cyc = 0;
  int   nChk = 0;
  int   nFail = 0;
  logic endChk = 1'b0;
  logic monDone = 1'b0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [63:0] initWord(int k);
    if (k == 8) return 64'h8877_6655_4433_2211;
    return {32'(k) * 32'h9E37_79B9, ~(32'(k) * 32'h85EB_CA6B)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gInst
    logic [63:0] mem [64];
    logic [63:0] dly [2];

    load_store_unit #(.READ_LAT(g == 0 ? 1 : 3)) dut (
      .Clk(Clk), .Reset(rstN[g]), .req(req[g]), .we(we[g]), .size(size[g]),
      .uns(uns[g]), .addr(addr[g]), .wdata(wdata[g]), .busy(busy[g]), .done(done[g]),
      .misalign(misalign[g]), .rdata(rdata[g]), .mem_addr(memAddr[g]), .mem_wr(memWr[g]),
      .mem_wdata(memWdata[g]), .mem_rdata(memRdata[g])
    );

    initial for (int k = 0; k < 64; k++) mem[k] = initWord(k);

    always @(posedge Clk) begin
      dly[0] <= mem[memAddr[g][8:3]];
      dly[1] <= dly[0];
      if (memWr[g] === 1'b1) mem[memAddr[g][8:3]] <= memWdata[g];
    end

    // Read data becomes valid only in the last cycle of a READ_LAT-cycle read.
    if (g == 0) begin : gLat1
      assign memRdata[g] = mem[memAddr[g][8:3]];
    end else begin : gLat3
      assign memRdata[g] = dly[1];
    end
  end

  task automatic check(string nm, int inst, logic [63:0] act, logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rstN[i] !== 1'b1) begin
        check("rst_busy", i, 64'(busy[i]), 64'd0);
        check("rst_done", i, 64'(done[i]), 64'd0);
        check("rst_misalign", i, 64'(misalign[i]), 64'd0);
        check("rst_mem_wr", i, 64'(memWr[i]), 64'd0);
        check("rst_rdata", i, rdata[i], 64'd0);
        check("rst_mem_addr", i, memAddr[i], 64'd0);
        check("rst_mem_wdata", i, memWdata[i], 64'd0);
      end else begin
        check("misalign_without_done", i, 64'(misalign[i] & ~done[i]), 64'd0);
        check("done_without_busy", i, 64'(done[i] & ~busy[i]), 64'd0);
        if (memWr[i] === 1'b1) begin
          check("write_expected", i, 64'(wrQ[i].size() != 0), 64'd1);
          if (wrQ[i].size() != 0) begin
            wrT w;
            w = wrQ[i].pop_front();
            check("write_addr", i, memAddr[i], w.maddr);
            check("write_data", i, memWdata[i], w.data);
            check("write_cycle", i, 64'(cyc - w.acc), 64'(w.off));
          end
        end
        if (done[i] === 1'b1) begin
          check("done_expected", i, 64'(expQ[i].size() != 0), 64'd1);
          if (expQ[i].size() != 0) begin
            expT e;
            e = expQ[i].pop_front();
            check("done_misalign", i, 64'(misalign[i]), 64'(e.mis));
            check("done_rdata", i, rdata[i], e.rd);
            check("done_latency", i, 64'(cyc - e.acc), 64'(e.doneOff));
          end
        end else if (busy[i] === 1'b1 && expQ[i].size() != 0) begin
          check("mem_addr_stable", i, memAddr[i], expQ[i][0].maddr);
        end
      end
    end
    if (endChk && !monDone) begin
      for (int i = 0; i < 2; i++) begin
        check("no_missing_done", i, 64'(expQ[i].size()), 64'd0);
        check("no_missing_write", i, 64'(wrQ[i].size()), 64'd0);
      end
      monDone = 1'b1;
    end
  end

  task automatic scramble(int i);
    req[i]   = 1'($urandom);
    we[i]    = 1'($urandom);
    size[i]  = 2'($urandom);
    uns[i]   = 1'($urandom);
    addr[i]  = {$urandom, $urandom};
    wdata[i] = {$urandom, $urandom};
  endtask

  // Call at a negedge; returns at a negedge with the instance idle.
  task automatic issue(int i, logic w, logic [1:0] sz, logic u, logic [63:0] a, logic [63:0] d);
    expT         e;
    wrT          wr;
    int          n, lat, t;
    logic [63:0] v;
    logic [8:0]  base, dw;
    t = 0;
    while (busy[i] !== 1'b0) begin
      @(negedge Clk);
      t++;
      if (t > 100) begin
        $display("FAIL busy_timeout inst%0d: busy stuck, expected idle", i);
        $fatal(1, "timeout");
      end
    end
    lat   = (i == 0) ? 1 : 3;
    n     = 1 << sz;
    base  = a[8:0];
    dw    = {base[8:3], 3'b000};
    e.maddr = {a[63:3], 3'b000};
    e.acc   = cyc + 1;
    e.mis   = (a[2:0] & 3'(n - 1)) != 3'd0;
    e.rd    = lastRd[i];
    if (e.mis) begin
      e.doneOff = 0;
    end else if (!w) begin
      v = 64'd0;
      for (int b = 0; b < n; b++) v |= 64'(refB[i][base + 9'(b)]) << (8 * b);
      if (!u && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
      e.rd      = v;
      lastRd[i] = v;
      e.doneOff = lat;
    end else begin
      for (int b = 0; b < n; b++) refB[i][base + 9'(b)] = d[8*b +: 8];
      v = 64'd0;
      for (int b = 0; b < 8; b++) v |= 64'(refB[i][dw + 9'(b)]) << (8 * b);
      wr.maddr = e.maddr;
      wr.data  = v;
      wr.acc   = e.acc;
      wr.off   = (n == 8) ? 0 : lat;
      wrQ[i].push_back(wr);
      e.doneOff = (n == 8) ? 1 : lat + 1;
    end
    expQ[i].push_back(e);
    req[i] = 1'b1; we[i] = w; size[i] = sz; uns[i] = u; addr[i] = a; wdata[i] = d;
    @(posedge Clk);
    #1 scramble(i);
    t = 0;
    do begin
      @(negedge Clk);
      if (busy[i] === 1'b1) scramble(i);
      t++;
      if (t > 100) begin
        $display("FAIL op_timeout inst%0d: busy stuck, expected idle", i);
        $fatal(1, "timeout");
      end
    end while (busy[i] === 1'b1);
    req[i] = 1'b0;
  endtask

  task automatic randomOps(int i, int count);
    logic [63:0] a;
    logic [1:0]  sz;
    for (int k = 0; k < count; k++) begin
      sz = 2'($urandom);
      a  = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      if ($urandom_range(0, 3) == 0) a = a | ({$urandom, $urandom} & ~64'h1FF);
      issue(i, 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom});
    end
  endtask

  initial begin
    logic [63:0] w;
    for (int i = 0; i < 2; i++) begin
      rstN[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; size[i] = 2'd0; uns[i] = 1'b0;
      addr[i] = 64'd0; wdata[i] = 64'd0; lastRd[i] = 64'd0;
      for (int k = 0; k < 64; k++) begin
        w = initWord(k);
        for (int b = 0; b < 8; b++) refB[i][8*k + b] = w[8*b +: 8];
      end
    end
    repeat (3) @(negedge Clk);
    rstN[0] = 1'b1;
    rstN[1] = 1'b1;
    @(negedge Clk);

    issue(0, 1'b0, 2'd0, 1'b0, 64'h47, 64'd0);
    issue(0, 1'b0, 2'd1, 1'b1, 64'h42, 64'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 64'h44, 64'd0);
    issue(0, 1'b1, 2'd1, 1'b0, 64'h44, 64'hDEAD_BEEF_0000_ABCD);
    issue(0, 1'b0, 2'd3, 1'b0, 64'h40, 64'd0);
    issue(0, 1'b1, 2'd3, 1'b0, 64'h48, 64'h0123_4567_89AB_CDEF);
    issue(0, 1'b0, 2'd2, 1'b0, 64'h46, 64'd0);
    randomOps(0, 150);

    // Abort a load in its second READ cycle; outputs must clear before the next edge.
    req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd0; uns[1] = 1'b0; addr[1] = 64'h45;
    @(posedge Clk);
    #1 req[1] = 1'b0;
    @(posedge Clk);
    #1 rstN[1] = 1'b0;
    lastRd[1] = 64'd0;
    repeat (2) @(negedge Clk);
    rstN[1] = 1'b1;
    issue(1, 1'b0, 2'd0, 1'b1, 64'h40, 64'd0);
    randomOps(1, 150);

    repeat (3) @(negedge Clk);
    endChk = 1'b1;
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
